// File: rtl/decision_sched.sv
// Round-robin arbiter that shares one decision-tree classifier engine among NREQ
// requesters, holds the engine's start for the whole job and aborts it on a watchdog timeout.
module decision_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*W-1:0] x1_i,
    input  logic [NREQ*W-1:0] x2_i,
    input  logic [NREQ*W-1:0] x3_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   done_o,
    output logic [W-1:0]      y_o,
    output logic              err_o,
    output logic              busy_o,
    output logic              eng_start_o,
    output logic [W-1:0]      eng_x1_o,
    output logic [W-1:0]      eng_x2_o,
    output logic [W-1:0]      eng_x3_o,
    input  logic [W-1:0]      eng_y_i,
    input  logic              eng_y_valid_i
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    localparam logic [NREQ-1:0] ONE      = NREQ'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]             state;
    logic [PW-1:0]          rr;
    logic [PW-1:0]          owner;
    logic [PW-1:0]          pick;
    logic                   found;
    logic [CW-1:0]          cnt;
    logic [NREQ-1:0][W-1:0] x1_a, x2_a, x3_a;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign x1_a[k] = x1_i[k*W +: W];
        assign x2_a[k] = x2_i[k*W +: W];
        assign x3_a[k] = x3_i[k*W +: W];
    end

    // first requester at or after the rr pointer, wrapping modulo NREQ
    always_comb begin
        logic [PW-1:0] idx;
        idx   = '0;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(rr) + i) % NREQ);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            rr          <= '0;
            owner       <= '0;
            cnt         <= '0;
            gnt_o       <= '0;
            done_o      <= '0;
            y_o         <= '0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
            eng_start_o <= 1'b0;
            eng_x1_o    <= '0;
            eng_x2_o    <= '0;
            eng_x3_o    <= '0;
        end else begin
            gnt_o  <= '0;
            done_o <= '0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        owner       <= pick;
                        eng_x1_o    <= x1_a[pick];
                        eng_x2_o    <= x2_a[pick];
                        eng_x3_o    <= x3_a[pick];
                        gnt_o       <= ONE << pick;
                        eng_start_o <= 1'b1;
                        busy_o      <= 1'b1;
                        cnt         <= '0;
                        state       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (cnt != '1) cnt <= cnt + CW'(1);
                    // an engine result on the watchdog's last cycle still counts as success
                    if (eng_y_valid_i) begin
                        y_o         <= eng_y_i;
                        err_o       <= 1'b0;
                        done_o      <= ONE << owner;
                        eng_start_o <= 1'b0;
                        state       <= S_REL;
                    end else if (cnt == CNT_LAST) begin
                        y_o         <= '1;
                        err_o       <= 1'b1;
                        done_o      <= ONE << owner;
                        eng_start_o <= 1'b0;
                        state       <= S_REL;
                    end
                end
                S_REL: begin
                    err_o  <= 1'b0;
                    busy_o <= 1'b0;
                    cnt    <= '0;
                    rr     <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
